// File: rtl/reset_seq_gen.sv
// reset_seq_gen: holds all NUM_CH channel resets for HOLD_CYCLES, then releases them in index order.
// Latency: channel 0 is released HOLD_CYCLES edges after start; each later channel >= max(STAGGER,1) edges after the previous one.
// Backpressure: a release waits (no timeout) for ch_ready of the previously released channel; DONE waits for all ch_ready.
// Optional macro RESET_SEQ_GEN_REQ_SYNC_EN: sw_req passes through a 2-flop synchronizer (2-cycle request lag).
module reset_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_req,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_reset,
    output logic              done,
    output logic [1:0]        state,
    output logic [7:0]        seq_cnt
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);
    localparam logic [7:0] STAG_LD = 8'(STAGGER);

    logic [7:0]        cnt;
    logic [IDX_W-1:0]  idx;
    logic              sw_eff;
    logic              cur_ready;
    logic              is_last;
    logic              gap_ok;
    logic              all_ready;
    logic [NUM_CH-1:0] next_mask;

`ifdef RESET_SEQ_GEN_REQ_SYNC_EN
    logic [1:0] req_sync;

    // Two-flop synchronizer for the software restart request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_sync <= 2'b00;
        end else begin
            req_sync <= {req_sync[0], sw_req};
        end
    end

    assign sw_eff = req_sync[1];
`else
    assign sw_eff = sw_req;
`endif

    // Select the ready bit of the most recently released channel and the one-hot of the next channel.
    always_comb begin
        cur_ready = 1'b0;
        next_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(idx)) begin
                cur_ready = ch_ready[i];
            end
            if (i == int'(idx) + 1) begin
                next_mask[i] = 1'b1;
            end
        end
    end

    assign is_last   = (int'(idx) == NUM_CH - 1);
    // cnt is loaded with STAGGER on a release and counts down each edge; a value of 1 or less
    // here means the decrement on this edge reaches zero, so STAGGER edges have elapsed
    // (STAGGER of 0 or 1 both give the one-edge minimum).
    assign gap_ok    = (cnt <= 8'd1);
    assign all_ready = &ch_ready;
    // done tracks ch_ready live while parked in DONE.
    assign done      = (state == ST_DONE) && all_ready;

    // Sequencer FSM: hold, staggered release, park in DONE; a request restarts from ASSERT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ASSERT;
            cnt      <= HOLD_LD;
            idx      <= '0;
            ch_reset <= '1;
            seq_cnt  <= 8'd0;
        end else if (sw_eff) begin
            state    <= ST_ASSERT;
            cnt      <= HOLD_LD;
            idx      <= '0;
            ch_reset <= '1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt <= 8'd1) begin
                        state       <= ST_RELEASE;
                        ch_reset[0] <= 1'b0;
                        idx         <= '0;
                        cnt         <= STAG_LD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                    if (is_last) begin
                        if (gap_ok && all_ready) begin
                            state <= ST_DONE;
                            if (seq_cnt != 8'hFF) begin
                                seq_cnt <= seq_cnt + 8'd1;
                            end
                        end
                    end else if (gap_ok && cur_ready) begin
                        ch_reset <= ch_reset & ~next_mask;
                        idx      <= idx + 1'b1;
                        cnt      <= STAG_LD;
                    end
                end
                ST_DONE: begin
                    // Released channels stay released; only a request or reset leaves DONE.
                end
                default: begin
                    state    <= ST_ASSERT;
                    cnt      <= HOLD_LD;
                    idx      <= '0;
                    ch_reset <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_seq_gen.sv
// tb_reset_seq_gen: checks reset_seq_gen (3 channels, hold 4, stagger 2) against a release-time model.
// Latency: compares every sampled cycle at the falling clock edge.
// Backpressure: drives ch_ready/sw_req at the falling edge, including random stalls and restarts.
module tb_reset_seq_gen;
    localparam int NUM_CH = 3;
    localparam int HOLD   = 4;
    localparam int STAG   = 2;
    localparam int GAPMIN = (STAG > 0) ? STAG : 1;
`ifdef RESET_SEQ_GEN_REQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              clk_run = 1'b0;
    logic              rst = 1'b0;
    logic              sw = 1'b0;
    logic [NUM_CH-1:0] ready = '1;
    logic [NUM_CH-1:0] ch_reset;
    logic              done;
    logic [1:0]        state;
    logic [7:0]        seq_cnt;

    int checks = 0;
    int passes = 0;

    reset_seq_gen #(.NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAG)) dut (
        .clk(clk), .reset(rst), .sw_req(sw), .ch_ready(ready),
        .ch_reset(ch_reset), .done(done), .state(state), .seq_cnt(seq_cnt)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
            else clk = 1'b0;
        end
    end

    // Reference model: tracks how many channels are released and the edge of the last release.
    typedef struct {
        int nrel;
        int hold;
        int last;
        int ecnt;
        bit dn;
        int seq;
        bit d1;
        bit d2;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_next(mdl_t s, logic swi, logic [NUM_CH-1:0] rdy);
        mdl_t n = s;
        bit eff;
        n.ecnt = s.ecnt + 1;
        eff = (SYNC_LAT == 2) ? s.d2 : swi;
        n.d2 = s.d1;
        n.d1 = swi;
        if (eff) begin
            n.nrel = 0; n.hold = 0; n.dn = 0;
        end else if (s.nrel == 0) begin
            n.hold = s.hold + 1;
            if (n.hold == HOLD) begin n.nrel = 1; n.last = n.ecnt; end
        end else if (!s.dn && (n.ecnt - s.last >= GAPMIN)) begin
            if (s.nrel < NUM_CH) begin
                if (rdy[s.nrel-1]) begin n.nrel = s.nrel + 1; n.last = n.ecnt; end
            end else if (&rdy) begin
                n.dn = 1;
                if (s.seq < 255) n.seq = s.seq + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= mdl_next(m, sw, ready);
    end

    logic [NUM_CH-1:0] m_ch_reset;
    always_comb begin
        m_ch_reset = '0;
        for (int i = 0; i < NUM_CH; i++) m_ch_reset[i] = (i >= m.nrel);
    end
    wire       m_done  = m.dn && (&ready);
    wire [1:0] m_state = (m.nrel == 0) ? 2'd0 : (m.dn ? 2'd2 : 2'd1);
    wire [7:0] m_seq   = 8'(m.seq);

    wire [13:0] dut_vec = {ch_reset, done, state, seq_cnt};
    wire [13:0] mdl_vec = {m_ch_reset, m_done, m_state, m_seq};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sw  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (dut_vec !== {3'b111, 1'b0, 2'd0, 8'd0})
            $display("FAIL reset_values: got %b want %b", dut_vec, {3'b111, 1'b0, 2'd0, 8'd0});
        else passes++;
        checks++;
        if (dut_vec !== mdl_vec) $display("FAIL reset_model: got %b want %b", dut_vec, mdl_vec);
        else passes++;
        clk_run = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0] exp_cr;
        ready = '1;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) $display("FAIL basic_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            else passes++;
            exp_cr = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 : (e < 8) ? 3'b100 : 3'b000;
            checks++;
            if (ch_reset !== exp_cr) $display("FAIL basic_ch_reset e=%0d: got %b want %b", e, ch_reset, exp_cr);
            else passes++;
            if (e == 9 || e == 10) begin
                checks++;
                if ({done, seq_cnt} !== ((e == 10) ? {1'b1, 8'd1} : {1'b0, 8'd0}))
                    $display("FAIL basic_done e=%0d: got done=%b seq_cnt=%0d", e, done, seq_cnt);
                else passes++;
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_cr;
        ready = 3'b110;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) $display("FAIL stall_model e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            else passes++;
            if (e >= 19 && e <= 22) begin
                exp_cr = (e == 19) ? 3'b110 : (e == 22) ? 3'b000 : 3'b100;
                checks++;
                if (ch_reset !== exp_cr) $display("FAIL stall_ch_reset e=%0d: got %b want %b", e, ch_reset, exp_cr);
                else passes++;
            end
            if (e == 19) ready = 3'b111;
        end
    endtask

    task automatic test_restart();
        int found = -1;
        int t;
        ready = '1;
        do_reset();
        repeat (12) @(negedge clk);
        sw = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            sw = 1'b0;
            checks++;
            if (dut_vec !== mdl_vec) $display("FAIL restart_model n=%0d: got %b want %b", n, dut_vec, mdl_vec);
            else passes++;
            if (found < 0 && ch_reset === 3'b111 && done === 1'b0) found = n;
        end
        checks++;
        if (found !== 1 + SYNC_LAT) $display("FAIL restart_latency: got %0d want %0d", found, 1 + SYNC_LAT);
        else passes++;
        t = 0;
        while (done !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (done !== 1'b1 || seq_cnt !== 8'd2)
            $display("FAIL restart_seq_cnt: got done=%b seq_cnt=%0d want done=1 seq_cnt=2", done, seq_cnt);
        else passes++;
    endtask

    task automatic test_async_reset();
        ready = '1;
        do_reset();
        repeat (12) @(negedge clk);
        sw = 1'b1;
        @(negedge clk);
        sw = 1'b0;
        repeat (SYNC_LAT + 5) @(negedge clk);
        checks++;
        if (state !== 2'd1 || dut_vec !== mdl_vec)
            $display("FAIL async_pre_state: got %b want %b (state 1)", dut_vec, mdl_vec);
        else passes++;
        clk_run = 1'b0;
        #7;
        rst = 1'b1;
        sw  = 1'b1;
        #2;
        checks++;
        if (dut_vec !== {3'b111, 1'b0, 2'd0, 8'd0})
            $display("FAIL async_immediate: got %b want %b", dut_vec, {3'b111, 1'b0, 2'd0, 8'd0});
        else passes++;
        clk_run = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== {3'b111, 1'b0, 2'd0, 8'd0})
                $display("FAIL async_override: got %b want %b", dut_vec, {3'b111, 1'b0, 2'd0, 8'd0});
            else passes++;
        end
        rst = 1'b0;
        sw  = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) $display("FAIL async_after e=%0d: got %b want %b", e, dut_vec, mdl_vec);
            else passes++;
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== mdl_vec) $display("FAIL random c=%0d: got %b want %b", c, dut_vec, mdl_vec);
            else passes++;
            for (int i = 0; i < NUM_CH; i++) ready[i] = ($urandom_range(0, 9) != 0);
            if (hold_left > 0) begin
                sw = 1'b1;
                hold_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                sw = 1'b1;
                hold_left = $urandom_range(0, 3);
            end else begin
                sw = 1'b0;
            end
        end
        sw = 1'b0;
        ready = '1;
    endtask

    task automatic test_saturation();
        int t;
        ready = '1;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            t = 0;
            while (done !== 1'b0 && t < 10) begin @(negedge clk); t++; end
            t = 0;
            while (done !== 1'b1 && t < 40) begin @(negedge clk); t++; end
            checks++;
            if (done !== 1'b1 || dut_vec !== mdl_vec || seq_cnt !== 8'((k > 255) ? 255 : k))
                $display("FAIL sat_seq k=%0d: got %b want %b", k, dut_vec, mdl_vec);
            else passes++;
            if (k < 256) begin
                sw = 1'b1;
                @(negedge clk);
                sw = 1'b0;
            end
        end
        checks++;
        if (seq_cnt !== 8'd255) $display("FAIL sat_final: got %0d want 255", seq_cnt);
        else passes++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_restart();
        test_async_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
